dct_core_scheduler: RTL and testbench

- Time-multiplexes one IG transform core (mode 0 = DCT, mode 1 = IDCT) between two block requesters: a DCT client and an IDCT client.
- Per job: arbitrates, pulses the core reset, sets the core mode, and formats the 22-bit core input for BLK_LEN cycles.
- Counts the core's pipeline latency and routes core output samples, with valid strobes, back to the client that owns the job.
- Sits between the codec front-end and the IG instance.

---
 rtl/dct_core_scheduler.sv | 169 ++++++++++++++++
 tb/tb_dct_core_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_core_scheduler.sv
// dct_core_scheduler: shares one IG DCT/IDCT transform core between a DCT
// client and an IDCT client, one block job at a time.
// Each job resets the core, sets its mode, streams BLK_LEN formatted samples
// in, and returns the core output to the owning client after LATENCY cycles.
// Optional build macro FIXED_PRIO_EN: when defined, DCT always wins a
// contested arbitration and no last-served state is kept. When undefined,
// contested requests alternate round-robin.
module dct_core_scheduler #(
  parameter int BLK_LEN = 64,
  parameter int LATENCY = 80,
  parameter int CW      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dct_req,
  output logic        dct_gnt,
  input  logic [7:0]  dct_din,
  output logic [11:0] dct_dout,
  output logic        dct_dvalid,
  input  logic        idct_req,
  output logic        idct_gnt,
  input  logic [11:0] idct_din,
  output logic [7:0]  idct_dout,
  output logic        idct_dvalid,
  output logic        core_rst,
  output logic        core_mode,
  output logic [21:0] core_din,
  input  logic [11:0] core_dct_out,
  input  logic [7:0]  core_idct_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CRST, FEED, DRAIN} state_e;

  localparam logic [CW-1:0] LAST_FEED = CW'(BLK_LEN - 1);
  localparam logic [CW-1:0] WIN_FIRST = CW'(LATENCY);
  localparam logic [CW-1:0] WIN_LAST  = CW'(LATENCY + BLK_LEN - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          owner_q;
  logic          dct_gnt_q, idct_gnt_q;
  logic          dct_dvalid_q, idct_dvalid_q;
  logic [11:0]   dct_dout_q;
  logic [7:0]    idct_dout_q;
  logic          core_rst_q, core_mode_q, busy_q;
  logic [21:0]   core_din_q;
`ifdef FIXED_PRIO_EN
`else
  logic          last_idct_q;
`endif

  logic          start_d;
  logic          win_idct_d;
  logic [CW-1:0] cnt_inc;
  logic          in_window;
  logic [21:0]   dct_fmt, idct_fmt;

  assign cnt_inc   = cnt_q + CW'(1);
  assign in_window = (cnt_inc >= WIN_FIRST) && (cnt_inc <= WIN_LAST);
  assign dct_fmt   = {1'b0, dct_din, 13'b0};
  assign idct_fmt  = {idct_din, 10'b0};

  // Pick the next job owner (1 = IDCT) from the current request levels.
  always_comb begin
    start_d    = dct_req | idct_req;
    win_idct_d = idct_req;
    if (dct_req && idct_req) begin
`ifdef FIXED_PRIO_EN
      win_idct_d = 1'b0;
`else
      win_idct_d = ~last_idct_q;
`endif
    end
  end

  // Job sequencer: all client and core outputs are registered here; the
  // output window is judged on the counter value of the coming cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      dct_gnt_q     <= 1'b0;
      idct_gnt_q    <= 1'b0;
      dct_dvalid_q  <= 1'b0;
      idct_dvalid_q <= 1'b0;
      dct_dout_q    <= '0;
      idct_dout_q   <= '0;
      core_rst_q    <= 1'b0;
      core_mode_q   <= 1'b0;
      core_din_q    <= '0;
      busy_q        <= 1'b0;
`ifdef FIXED_PRIO_EN
`else
      last_idct_q   <= 1'b1;
`endif
    end else begin
      core_rst_q    <= 1'b1;
      dct_gnt_q     <= 1'b0;
      idct_gnt_q    <= 1'b0;
      dct_dvalid_q  <= 1'b0;
      idct_dvalid_q <= 1'b0;
      dct_dout_q    <= '0;
      idct_dout_q   <= '0;
      core_din_q    <= '0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            owner_q     <= win_idct_d;
            core_mode_q <= win_idct_d;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CRST;
          end
        end
        CRST: begin
          cnt_q      <= '0;
          dct_gnt_q  <= ~owner_q;
          idct_gnt_q <= owner_q;
          state_q    <= FEED;
        end
        FEED: begin
          cnt_q      <= cnt_inc;
          core_din_q <= owner_q ? idct_fmt : dct_fmt;
          if (cnt_q == LAST_FEED) begin
            state_q <= DRAIN;
          end else begin
            dct_gnt_q  <= ~owner_q;
            idct_gnt_q <= owner_q;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_inc;
          if (cnt_q == WIN_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
`ifdef FIXED_PRIO_EN
`else
            last_idct_q <= owner_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
      if ((state_q == FEED || state_q == DRAIN) && in_window) begin
        if (owner_q) begin
          idct_dvalid_q <= 1'b1;
          idct_dout_q   <= core_idct_out;
        end else begin
          dct_dvalid_q <= 1'b1;
          dct_dout_q   <= core_dct_out;
        end
      end
    end
  end

  assign dct_gnt     = dct_gnt_q;
  assign idct_gnt    = idct_gnt_q;
  assign dct_dvalid  = dct_dvalid_q;
  assign idct_dvalid = idct_dvalid_q;
  assign dct_dout    = dct_dout_q;
  assign idct_dout   = idct_dout_q;
  assign core_rst    = core_rst_q;
  assign core_mode   = core_mode_q;
  assign core_din    = core_din_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dct_core_scheduler.sv
// tb_dct_core_scheduler: randomized self-checking bench for the DCT/IDCT
// core scheduler. A stand-in core is a pure delay line with simple
// invertible transforms, so returned samples can be predicted per index.
module tb_dct_core_scheduler;

  localparam int BLK = 64;
  localparam int LAT = 80;
  localparam int DLY = LAT - 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dct_req = 1'b0, idct_req = 1'b0;
  logic [7:0]  dct_din = '0;
  logic [11:0] idct_din = '0;
  logic        dct_gnt, idct_gnt, dct_dvalid, idct_dvalid;
  logic [11:0] dct_dout;
  logic [7:0]  idct_dout;
  logic        core_rst, core_mode, busy;
  logic [21:0] core_din;
  logic [11:0] core_dct_out;
  logic [7:0]  core_idct_out;

  int vecCount = 0;
  int missCount = 0;

  logic [7:0]  pixStim [BLK];
  logic [11:0] coefStim[BLK];
  logic [11:0] capDct  [BLK];
  logic [7:0]  capIdct [BLK];
  logic [21:0] hist    [DLY];

  dct_core_scheduler #(.BLK_LEN(BLK), .LATENCY(LAT), .CW(9)) dut (
    .clk(clk), .rst(rst_n),
    .dct_req(dct_req), .dct_gnt(dct_gnt), .dct_din(dct_din),
    .dct_dout(dct_dout), .dct_dvalid(dct_dvalid),
    .idct_req(idct_req), .idct_gnt(idct_gnt), .idct_din(idct_din),
    .idct_dout(idct_dout), .idct_dvalid(idct_dvalid),
    .core_rst(core_rst), .core_mode(core_mode), .core_din(core_din),
    .core_dct_out(core_dct_out), .core_idct_out(core_idct_out),
    .busy(busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Stand-in core pipeline: output is a fixed function of core_din DLY cycles ago.
  always @(posedge clk) begin
    for (int k = DLY - 1; k > 0; k--) hist[k] <= hist[k-1];
    hist[0] <= core_din;
  end

  assign core_dct_out  = {hist[DLY-1][20:13] ^ 8'hA5, 4'h6};
  assign core_idct_out = hist[DLY-1][21:14] ^ 8'hA5;

  function automatic logic [11:0] refDct(input logic [7:0] p);
    return {p ^ 8'hA5, 4'h6};
  endfunction

  function automatic logic [7:0] refIdct(input logic [11:0] c);
    return c[11:4] ^ 8'hA5;
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < BLK; i++) begin
      pixStim[i]  = 8'($urandom);
      coefStim[i] = 12'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dct_req = 1'b0;
    idct_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one job from the current negedge until busy falls, checking grants,
  // core formatting, output timing and data against the per-index model.
  task automatic run_job(input bit expIdct, input bit dropReq, input bit checkCrst,
                         input int raiseAt, input string tag);
    int gntCnt = 0, valCnt = 0, otherCnt = 0, crstCnt = 0;
    int firstGnt = -1, firstVal = -1, obsOwner = -1;
    bit seenBusy = 0, done = 0, prevGnt = 0;
    logic [21:0] prevFmt = '0, expFmt;
    logic ownGnt, othGnt, ownVal, othVal, othDoutNz;
    logic [11:0] expD;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      ownGnt    = expIdct ? idct_gnt : dct_gnt;
      othGnt    = expIdct ? dct_gnt : idct_gnt;
      ownVal    = expIdct ? idct_dvalid : dct_dvalid;
      othVal    = expIdct ? dct_dvalid : idct_dvalid;
      othDoutNz = expIdct ? (dct_dout != 0) : (idct_dout != 0);
      if (obsOwner < 0 && (dct_gnt || idct_gnt)) begin
        obsOwner = idct_gnt ? 1 : 0;
        firstGnt = cyc;
      end
      if (busy) begin
        vecCount++;
        if (core_mode !== logic'(expIdct)) begin
          missCount++;
          $display("[TB] FAIL %s core_mode: got %b want %b", tag, core_mode, expIdct);
        end
      end
      expFmt = prevGnt ? prevFmt : 22'd0;
      vecCount++;
      if (core_din !== expFmt) begin
        missCount++;
        $display("[TB] FAIL %s core_din: got %h want %h", tag, core_din, expFmt);
      end
      if (core_rst === 1'b0) crstCnt++;
      prevGnt = 0;
      if (ownGnt) begin
        if (gntCnt < BLK) begin
          if (expIdct) begin
            idct_din = coefStim[gntCnt];
            prevFmt  = {coefStim[gntCnt], 10'b0};
          end else begin
            dct_din = pixStim[gntCnt];
            prevFmt = {1'b0, pixStim[gntCnt], 13'b0};
          end
        end
        prevGnt = 1;
        gntCnt++;
        if (dropReq) begin
          if (expIdct) idct_req = 1'b0;
          else dct_req = 1'b0;
        end
      end
      if (othGnt) otherCnt++;
      if (ownVal) begin
        if (firstVal < 0) firstVal = cyc;
        if (valCnt < BLK) begin
          expD = expIdct ? {4'h0, refIdct(coefStim[valCnt])} : refDct(pixStim[valCnt]);
          vecCount++;
          if (expIdct) begin
            capIdct[valCnt] = idct_dout;
            if ({4'h0, idct_dout} !== expD) begin
              missCount++;
              $display("[TB] FAIL %s idct_dout[%0d]: got %h want %h", tag, valCnt, idct_dout, expD[7:0]);
            end
          end else begin
            capDct[valCnt] = dct_dout;
            if (dct_dout !== expD) begin
              missCount++;
              $display("[TB] FAIL %s dct_dout[%0d]: got %h want %h", tag, valCnt, dct_dout, expD);
            end
          end
        end
        valCnt++;
      end
      if (othVal || othDoutNz) otherCnt++;
      if (raiseAt >= 0 && firstGnt >= 0 && cyc - firstGnt == raiseAt) idct_req = 1'b1;
      if (busy) seenBusy = 1;
      else if (seenBusy) done = 1;
      if (!done) @(negedge clk);
    end
    vecCount++;
    if (!done) begin
      missCount++;
      $display("[TB] FAIL %s timeout: job did not finish, got busy=%b want 0", tag, busy);
    end
    vecCount++;
    if (obsOwner != int'(expIdct)) begin
      missCount++;
      $display("[TB] FAIL %s owner: got %0d want %0d", tag, obsOwner, expIdct);
    end
    vecCount++;
    if (gntCnt != BLK) begin
      missCount++;
      $display("[TB] FAIL %s gnt_cycles: got %0d want %0d", tag, gntCnt, BLK);
    end
    vecCount++;
    if (valCnt != BLK) begin
      missCount++;
      $display("[TB] FAIL %s dvalid_cycles: got %0d want %0d", tag, valCnt, BLK);
    end
    vecCount++;
    if (firstVal - firstGnt != LAT) begin
      missCount++;
      $display("[TB] FAIL %s latency: got %0d want %0d", tag, firstVal - firstGnt, LAT);
    end
    vecCount++;
    if (otherCnt != 0) begin
      missCount++;
      $display("[TB] FAIL %s non_owner_activity: got %0d want 0", tag, otherCnt);
    end
    if (checkCrst) begin
      vecCount++;
      if (crstCnt != 1) begin
        missCount++;
        $display("[TB] FAIL %s core_rst_low_cycles: got %0d want 1", tag, crstCnt);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vecCount++;
      if ({core_rst, busy, dct_gnt, idct_gnt, dct_dvalid, idct_dvalid, core_mode} !== 7'b0 ||
          core_din !== 22'd0 || dct_dout !== 12'd0 || idct_dout !== 8'd0) begin
        missCount++;
        $display("[TB] FAIL reset_state: got rst=%b busy=%b gnt=%b%b val=%b%b mode=%b din=%h want all 0",
                 core_rst, busy, dct_gnt, idct_gnt, dct_dvalid, idct_dvalid, core_mode, core_din);
      end
    end
    rst_n = 1'b1;
    #1;
    vecCount++;
    if (core_rst !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL core_rst_at_release: got %b want 0", core_rst);
    end
    @(negedge clk);
    vecCount++;
    if (core_rst !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL core_rst_after_release: got %b want 1", core_rst);
    end
    repeat (4) begin
      @(negedge clk);
      vecCount++;
      if ({busy, dct_gnt, idct_gnt, dct_dvalid, idct_dvalid} !== 5'b0) begin
        missCount++;
        $display("[TB] FAIL idle_quiet: got %b want 00000", {busy, dct_gnt, idct_gnt, dct_dvalid, idct_dvalid});
      end
    end
  endtask

  task automatic test_single_dct();
    for (int i = 0; i < BLK; i++) pixStim[i] = 8'(i);
    dct_req = 1'b1;
    run_job(1'b0, 1'b1, 1'b1, -1, "single_dct");
  endtask

  task automatic test_loopback();
    logic [7:0] orig[BLK];
    fillRandom();
    for (int i = 0; i < BLK; i++) orig[i] = pixStim[i];
    dct_req = 1'b1;
    run_job(1'b0, 1'b1, 1'b1, -1, "loop_dct");
    for (int i = 0; i < BLK; i++) coefStim[i] = capDct[i];
    idct_req = 1'b1;
    run_job(1'b1, 1'b1, 1'b1, -1, "loop_idct");
    for (int i = 0; i < BLK; i++) begin
      vecCount++;
      if (capIdct[i] !== orig[i]) begin
        missCount++;
        $display("[TB] FAIL loopback_pixel[%0d]: got %h want %h", i, capIdct[i], orig[i]);
      end
    end
  endtask

  task automatic test_contention();
    bit expIdct;
    apply_reset();
    dct_req = 1'b1;
    idct_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      fillRandom();
`ifdef FIXED_PRIO_EN
      expIdct = 1'b0;
`else
      expIdct = (j % 2) == 1;
`endif
      run_job(expIdct, 1'b0, 1'b1, -1, "contend");
    end
    dct_req = 1'b0;
    idct_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int k;
    fillRandom();
    dct_req = 1'b1;
    k = 0;
    while (!dct_gnt && k < 20) begin
      @(negedge clk);
      k++;
    end
    vecCount++;
    if (!dct_gnt) begin
      missCount++;
      $display("[TB] FAIL midrst_start: got gnt=%b want 1", dct_gnt);
    end
    dct_req = 1'b0;
    k = 0;
    while (k < 100) begin
      if (dct_gnt) dct_din = 8'($urandom);
      @(negedge clk);
      k++;
    end
    vecCount++;
    if (dct_dvalid !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL midrst_pre_dvalid: got %b want 1", dct_dvalid);
    end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if ({dct_dvalid, busy, core_rst, dct_gnt} !== 4'b0 || dct_dout !== 12'd0) begin
      missCount++;
      $display("[TB] FAIL midrst_abort: got val=%b busy=%b crst=%b gnt=%b dout=%h want 0",
               dct_dvalid, busy, core_rst, dct_gnt, dct_dout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vecCount++;
    if ({dct_dvalid, idct_dvalid, busy} !== 3'b0) begin
      missCount++;
      $display("[TB] FAIL midrst_after: got %b want 000", {dct_dvalid, idct_dvalid, busy});
    end
    fillRandom();
    dct_req = 1'b1;
    run_job(1'b0, 1'b1, 1'b1, -1, "midrst_new");
  endtask

  task automatic test_late_request();
    int w;
    fillRandom();
    dct_req = 1'b1;
    idct_req = 1'b0;
    run_job(1'b0, 1'b1, 1'b1, 100, "late_dct");
    w = 0;
    while (!idct_gnt && w < 10) begin
      vecCount++;
      if (dct_dvalid !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL late_overlap: got dct_dvalid=%b want 0", dct_dvalid);
      end
      @(negedge clk);
      w++;
    end
    vecCount++;
    if (w != 2) begin
      missCount++;
      $display("[TB] FAIL late_gnt_delay: got %0d want 2", w);
    end
    run_job(1'b1, 1'b1, 1'b0, -1, "late_idct");
  endtask

  // Hard stop so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    for (int k = 0; k < DLY; k++) hist[k] = '0;
    #1;
    test_reset();
    test_single_dct();
    test_loopback();
    test_contention();
    test_mid_reset();
    test_late_request();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
